// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter that time-shares one bitwise gate unit (AND/OR/XOR/NAND)
// among NREQ requesters, with a programmable execute latency and a valid/ready response.
module gate_unit_arbiter #(
  parameter  int NREQ    = 4,
  parameter  int WIDTH   = 8,
  parameter  int LATENCY = 1,
  localparam int ID_W    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] a,
  input  logic [WIDTH*NREQ-1:0] b,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [WIDTH-1:0]      rsp_data
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_reg;
  logic [ID_W-1:0]   ptr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [NREQ-1:0]   gnt_reg;
  logic              busy_reg;
  logic              rsp_valid_reg;
  logic [ID_W-1:0]   rsp_id_reg;
  logic [WIDTH-1:0]  rsp_data_reg;
  logic [1:0]        op_cap_reg;
  logic [WIDTH-1:0]  a_cap_reg;
  logic [WIDTH-1:0]  b_cap_reg;

  logic [1:0]        op_arr [NREQ];
  logic [WIDTH-1:0]  a_arr  [NREQ];
  logic [WIDTH-1:0]  b_arr  [NREQ];

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [NREQ-1:0]   rot_first;
  logic [NREQ-1:0]   win_onehot;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   ptr_next;
  int                win_off;
  int                win_pos;
  int                nxt_pos;
  logic [1:0]        sel_op;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;

  genvar gi;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign op_arr[gi] = op[2*gi +: 2];
      assign a_arr[gi]  = a[WIDTH*gi +: WIDTH];
      assign b_arr[gi]  = b[WIDTH*gi +: WIDTH];
    end
  endgenerate

  // Rotate requests so bit 0 is the requester at ptr; the first set bit wins.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr_reg +: NREQ];

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_prio
      if (gi == 0) begin : g_first
        assign rot_first[gi] = req_rot[gi];
      end else begin : g_rest
        assign rot_first[gi] = req_rot[gi] & ~(|req_rot[gi-1:0]);
      end
    end
  endgenerate

  always_comb begin
    win_off = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (rot_first[k]) begin
        win_off = k;
      end
    end
    win_pos = int'(ptr_reg) + win_off;
    if (win_pos >= NREQ) begin
      win_pos = win_pos - NREQ;
    end
    nxt_pos = win_pos + 1;
    if (nxt_pos >= NREQ) begin
      nxt_pos = 0;
    end
    win_idx  = ID_W'(win_pos);
    ptr_next = ID_W'(nxt_pos);
  end

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_idx == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_onehot[k]) begin
        sel_op = op_arr[k];
        sel_a  = a_arr[k];
        sel_b  = b_arr[k];
      end
    end
  end

  function automatic logic [WIDTH-1:0] gate_fn(
    input logic [1:0]       f,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    case (f)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      cnt_reg       <= '0;
      gnt_reg       <= '0;
      busy_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_data_reg  <= '0;
      op_cap_reg    <= '0;
      a_cap_reg     <= '0;
      b_cap_reg     <= '0;
    end else begin
      gnt_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (|req) begin
            gnt_reg    <= win_onehot;
            op_cap_reg <= sel_op;
            a_cap_reg  <= sel_a;
            b_cap_reg  <= sel_b;
            rsp_id_reg <= win_idx;
            cnt_reg    <= CNT_W'(LATENCY - 1);
            ptr_reg    <= ptr_next;
            busy_reg   <= 1'b1;
            state_reg  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_reg == '0) begin
            rsp_data_reg  <= gate_fn(op_cap_reg, a_cap_reg, b_cap_reg);
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        RESP: begin
          // Result stays stable until the consumer takes it.
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign busy      = busy_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Bench for gate_unit_arbiter: LATENCY=1 and LATENCY=3 instances share stimulus and
// are each compared every cycle against a transaction-level reference model.
module tb_gate_unit_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [2*N-1:0] op;
  logic [W*N-1:0] a;
  logic [W*N-1:0] b;
  logic           rsp_ready;

  logic [N-1:0]   gnt0, gnt1;
  logic           busy0, busy1, v0, v1;
  logic [1:0]     id0, id1;
  logic [W-1:0]   d0, d1;

  always #5 clk = ~clk;

  gate_unit_arbiter #(.NREQ(N), .WIDTH(W), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b),
    .gnt(gnt0), .busy(busy0), .rsp_valid(v0), .rsp_ready(rsp_ready),
    .rsp_id(id0), .rsp_data(d0)
  );

  gate_unit_arbiter #(.NREQ(N), .WIDTH(W), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b),
    .gnt(gnt1), .busy(busy1), .rsp_valid(v1), .rsp_ready(rsp_ready),
    .rsp_id(id1), .rsp_data(d1)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state, one slot per instance.
  int           lat [2] = '{1, 3};
  int           m_ptr [2];
  int           m_age [2];
  bit           m_idle [2];
  bit           m_valid [2];
  int           m_id [2];
  logic [W-1:0] m_data [2];
  logic [W-1:0] m_res [2];
  logic [N-1:0] m_gnt [2];

  logic [W-1:0] t3_tbl [4] = '{8'hFC, 8'hCC, 8'hCF, 8'h30};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_gate(input int f, input logic [W-1:0] x, input logic [W-1:0] y);
    case (f)
      0:       return x & y;
      1:       return x | y;
      2:       return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d]   = 0;
      m_age[d]   = 0;
      m_idle[d]  = 1'b1;
      m_valid[d] = 1'b0;
      m_id[d]    = 0;
      m_data[d]  = '0;
      m_res[d]   = '0;
      m_gnt[d]   = '0;
    end
  endtask

  // Predict the effect of the coming rising edge given the inputs now applied.
  task automatic step();
    int w;
    int i;
    for (int d = 0; d < 2; d++) begin
      m_gnt[d] = '0;
      if (m_idle[d]) begin
        if (req != '0) begin
          w = -1;
          for (int k = 0; k < N; k++) begin
            i = (m_ptr[d] + k) % N;
            if (w < 0 && req[i]) w = i;
          end
          m_gnt[d]  = 4'b0001 << w;
          m_id[d]   = w;
          m_res[d]  = ref_gate(int'(op[2*w +: 2]), a[W*w +: W], b[W*w +: W]);
          m_ptr[d]  = (w + 1) % N;
          m_idle[d] = 1'b0;
          m_age[d]  = 0;
        end
      end else if (!m_valid[d]) begin
        m_age[d]++;
        if (m_age[d] == lat[d]) begin
          m_valid[d] = 1'b1;
          m_data[d]  = m_res[d];
        end
      end else if (rsp_ready) begin
        m_valid[d] = 1'b0;
        m_idle[d]  = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("gnt_l1",  32'(gnt0),  32'(m_gnt[0]));
    chk("busy_l1", 32'(busy0), 32'(!m_idle[0]));
    chk("vld_l1",  32'(v0),    32'(m_valid[0]));
    chk("id_l1",   32'(id0),   32'(m_id[0]));
    chk("data_l1", 32'(d0),    32'(m_data[0]));
    chk("gnt_l3",  32'(gnt1),  32'(m_gnt[1]));
    chk("busy_l3", 32'(busy1), 32'(!m_idle[1]));
    chk("vld_l3",  32'(v1),    32'(m_valid[1]));
    chk("id_l3",   32'(id1),   32'(m_id[1]));
    chk("data_l3", 32'(d1),    32'(m_data[1]));
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_op(input int i, input int f, input logic [W-1:0] av, input logic [W-1:0] bv);
    op[2*i +: 2] = 2'(f);
    a[W*i +: W]  = av;
    b[W*i +: W]  = bv;
  endtask

  // Assert reset in the middle of the next high phase, then release at the following negedge.
  task automatic apply_reset(input logic [N-1:0] r);
    step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    req = r;
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    op        = '0;
    a         = '0;
    b         = '0;
    rsp_ready = 1'b1;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    step();
    tick();

    // Single AND request
    set_op(0, 0, 8'hA5, 8'h0F);
    req = 4'b0001;
    step(); tick();
    chk("t2_gnt", 32'(gnt0), 32'h1);
    req = '0;
    step(); tick();
    chk("t2_valid", 32'(v0), 32'h1);
    chk("t2_data", 32'(d0), 32'h05);
    chk("t2_id", 32'(id0), 32'h0);
    step(); tick();
    chk("t2_valid_drop", 32'(v0), 32'h0);
    for (int k = 0; k < 6; k++) begin
      step(); tick();
    end

    // LATENCY=3 timing, with req dropped during execute
    req = 4'b0001;
    step(); tick();
    chk("t5_gnt", 32'(gnt1), 32'h1);
    req = '0;
    for (int k = 1; k <= 4; k++) begin
      step(); tick();
      chk("t5_lat", 32'(v1), 32'(k == 3));
    end
    step(); tick();

    // Reset mid-cycle with all requesting, then round robin
    set_op(0, 1, 8'hF0, 8'h3C);
    set_op(1, 2, 8'hF0, 8'h3C);
    set_op(2, 3, 8'hF0, 8'h3C);
    set_op(3, 0, 8'hF0, 8'h3C);
    apply_reset(4'b1111);
    for (int k = 0; k < 15; k++) begin
      if (k > 0) step();
      tick();
      chk("t3_gnt", 32'(gnt0), (k % 3 == 0) ? (32'h1 << ((k / 3) % 4)) : 32'h0);
      if (k % 3 == 1) begin
        chk("t3_data", 32'(d0), 32'(t3_tbl[(k / 3) % 4]));
        chk("t3_id", 32'(id0), 32'((k / 3) % 4));
      end
    end

    // Backpressure in RESP
    apply_reset('0);
    tick();
    set_op(0, 0, 8'hA5, 8'h0F);
    req       = 4'b0001;
    rsp_ready = 1'b0;
    step(); tick();
    chk("t4_gnt", 32'(gnt0), 32'h1);
    req = 4'b0110;
    for (int k = 0; k < 6; k++) begin
      step(); tick();
      chk("t4_hold_vld", 32'(v0), 32'h1);
      chk("t4_hold_data", 32'(d0), 32'h05);
      chk("t4_no_gnt", 32'(gnt0), 32'h0);
      chk("t4_busy", 32'(busy0), 32'h1);
    end
    rsp_ready = 1'b1;
    step(); tick();
    chk("t4_handshake", 32'(v0), 32'h0);
    step(); tick();
    chk("t4_next_gnt", 32'(gnt0), 32'h2);
    for (int k = 0; k < 6; k++) begin
      step(); tick();
    end

    // Reset while executing: result discarded, ptr restarts at 0
    req = '0;
    apply_reset('0);
    tick();
    req = 4'b0100;
    step(); tick();
    chk("t6_gnt", 32'(gnt0), 32'h4);
    apply_reset(4'b0110);
    tick();
    chk("t6_gnt_after_l1", 32'(gnt0), 32'h2);
    chk("t6_gnt_after_l3", 32'(gnt1), 32'h2);
    req = '0;
    step(); tick();
    chk("t6_id", 32'(id0), 32'h1);
    for (int k = 0; k < 5; k++) begin
      step(); tick();
    end

    // Randomized traffic with occasional resets and backpressure
    for (int it = 0; it < 600; it++) begin
      op = 8'($urandom);
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 59) == 0) begin
        apply_reset(4'($urandom));
        tick();
      end else begin
        req       = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
        rsp_ready = ($urandom_range(0, 3) != 0);
        step();
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
